lsu_mem_master: RTL and testbench

Load/store initiator for the MEM stage of the pipelined core, driving the byte-addressed, big-endian data memory (word write port, slow combinational read). Converts pipeline requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into aligned word accesses. Sub-word stores use read-modify-write, because the memory writes 4 bytes per write enable. Stalls the pipeline via a valid/ready handshake while the slow read settles.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_mem_master_if.sv | 33 +++
 rtl/lsu_lane_merge.sv | 44 ++++
 rtl/lsu_mem_master.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the big-endian lane position helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WRITE   = 2'd2
  } lsu_state_e;

  // Big-endian: byte offset 0 lives in bits [31:24], offset 3 in bits [7:0].
  function automatic logic [4:0] lane_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// master = the LSU itself, slave = the pipeline/memory environment.
interface lsu_mem_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_re, mem_we, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_merge.sv
// Combinational big-endian lane logic: load extract + sign/zero extension,
// and merge of sub-word store data into the word read back from memory.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // A half always starts at offset 0 or 2, so force the low offset bit.
  assign ld_byte = rdata[lane_lsb(offset) +: 8];
  assign ld_half = rdata[lane_lsb({offset[1], 1'b1}) +: 16];

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      default: load_data = rdata;
    endcase
  end

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic sel_byte;
    logic sel_half;

    assign sel_byte = (size == SZ_BYTE) && (offset == LANE);
    assign sel_half = (size == SZ_HALF) && (offset[1] == LANE[1]);
    // Within a half, the even lane takes the upper store byte.
    assign merge_data[31-8*gi -: 8] = sel_byte ? wdata[7:0] :
                                      sel_half ? (LANE[0] ? wdata[7:0] : wdata[15:8]) :
                                                 rdata[31-8*gi -: 8];
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the MEM stage: aligned word accesses, RMW for
// sub-word stores. Build option LSU_MISALIGN_ERR_EN reports misaligned
// half/word accesses as errors instead of silently aligning them.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MEM_BYTES    = 1024
) (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_master_if.master bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  lsu_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       addr_reg;
  logic [1:0]        off_reg;
  logic [1:0]        size_reg;
  logic              unsigned_reg;
  logic              we_reg;
  logic [15:0]       wdata_reg;
  logic [31:0]       mem_wdata_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [31:0]       resp_rdata_reg;
  logic              err_pend_reg;

  logic              accept;
  logic              misalign;
  logic              range_err;
  logic              req_err;
  logic              word_store;
  logic [31:0]       eff_addr;
  logic [32:0]       range_end;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

`ifdef LSU_MISALIGN_ERR_EN
  assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign eff_addr = bus.req_addr;
`else
  assign misalign = 1'b0;
  always_comb begin
    eff_addr = bus.req_addr;
    if (bus.req_size == SZ_HALF)
      eff_addr[0] = 1'b0;
    else if (bus.req_size == SZ_WORD)
      eff_addr[1:0] = 2'b00;
  end
`endif

  // 33 bits so addresses near 2^32 cannot wrap past the bound.
  assign range_end  = {1'b0, eff_addr[31:2], 2'b00} + 33'd3;
  assign range_err  = (range_end >= 33'(MEM_BYTES));
  assign req_err    = (bus.req_size == SZ_ILL) || misalign || range_err;
  assign word_store = bus.req_we && (bus.req_size == SZ_WORD);

  // An error is answered from IDLE one cycle later; hold off new requests meanwhile.
  assign bus.req_ready = rst_n && (state_reg == ST_IDLE) && !err_pend_reg;
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !req_err)
          state_next = word_store ? ST_WRITE : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        bus.mem_re = 1'b1;
        if (cnt_reg == '0)
          state_next = we_reg ? ST_WRITE : ST_IDLE;
      end
      ST_WRITE: begin
        bus.mem_we = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      addr_reg       <= '0;
      off_reg        <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      err_pend_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      err_pend_reg   <= 1'b0;

      if (accept) begin
        addr_reg     <= {eff_addr[31:2], 2'b00};
        off_reg      <= eff_addr[1:0];
        size_reg     <= bus.req_size;
        unsigned_reg <= bus.req_unsigned;
        we_reg       <= bus.req_we;
        wdata_reg    <= bus.req_wdata[15:0];
        cnt_reg      <= CNT_W'(READ_LATENCY - 1);
        err_pend_reg <= req_err;
        if (word_store && !req_err)
          mem_wdata_reg <= bus.req_wdata;
      end

      if (err_pend_reg) begin
        resp_valid_reg <= 1'b1;
        resp_err_reg   <= 1'b1;
      end

      // The read word is consumed on the edge that ends the last read cycle.
      if (state_reg == ST_RD_WAIT) begin
        if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end else if (we_reg) begin
          mem_wdata_reg <= merge_data;
        end else begin
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= load_data;
        end
      end

      if (state_reg == ST_WRITE)
        resp_valid_reg <= 1'b1;
    end
  end

  lsu_lane_merge u_lane_merge (
    .size        (size_reg),
    .offset      (off_reg),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .rdata       (bus.mem_rdata),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a slow-read,
// big-endian word memory model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int RL = 2;
  localparam int MB = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp;
  } ld_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_master_if bus();

  lsu_mem_master #(.READ_LATENCY(RL), .MEM_BYTES(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem_words [0:255];
  int          re_run = 0;
  int          re_total = 0;
  int          we_total = 0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;
  logic        both_seen = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  int          checks = 0;
  int          errors = 0;

  // Read data is only meaningful once the strobe has been held long enough.
  assign bus.mem_rdata = (bus.mem_re && re_run >= RL - 1) ? mem_words[bus.mem_addr[9:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (bus.mem_re && bus.mem_we) both_seen <= 1'b1;
    if (bus.mem_re) begin
      re_total <= re_total + 1;
      re_run   <= re_run + 1;
    end else begin
      re_run <= 0;
    end
    if (bus.mem_we) begin
      we_total     <= we_total + 1;
      last_we_addr <= bus.mem_addr;
      last_we_data <= bus.mem_wdata;
      mem_words[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end else if (pl_en) begin
      mem_words[pl_idx] <= pl_data;
    end
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int n_re, output int n_we, output logic rdy);
    int re0, we0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    re0 = re_total; we0 = we_total;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) begin lat = i; break; end
    end
    rdata = bus.resp_rdata; err = bus.resp_err; rdy = bus.req_ready;
    n_re = re_total - re0; n_we = we_total - we0;
    $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d re=%0d we=%0d",
             we, size, uns, addr, wdata, lat, rdata, err, n_re, n_we);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_WORD;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", bus.resp_valid); end
    checks++; if ({bus.mem_re, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {bus.mem_re, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 00000000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 00000000", bus.mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_load_word();
    int lat, n_re, n_we; logic [31:0] rd; logic err, rdy;
    preload(32'h10, 32'h11223344);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (lat !== RL) begin errors++; $display("FAIL lw_latency: got %0d expected %0d", lat, RL); end
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_data: got %h expected 11223344", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", err); end
    checks++; if (n_we !== 0) begin errors++; $display("FAIL lw_no_write: got %0d expected 0", n_we); end
    checks++; if (n_re !== RL) begin errors++; $display("FAIL lw_re_cycles: got %0d expected %0d", n_re, RL); end
  endtask

  task automatic test_load_sub();
    int lat, n_re, n_we; logic [31:0] rd; logic err, rdy;
    ld_vec_t v[6];
    v[0] = '{32'h13, SZ_BYTE, 1'b0, 32'hFFFFFFF4};
    v[1] = '{32'h13, SZ_BYTE, 1'b1, 32'h000000F4};
    v[2] = '{32'h10, SZ_HALF, 1'b0, 32'h00001122};
    v[3] = '{32'h12, SZ_HALF, 1'b1, 32'h000033F4};
    v[4] = '{32'h11, SZ_BYTE, 1'b0, 32'h00000022};
    v[5] = '{32'h14, SZ_HALF, 1'b0, 32'hFFFF8001};
    preload(32'h10, 32'h112233F4);
    preload(32'h14, 32'h80017FFF);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, v[i].size, v[i].uns, v[i].addr, 32'h0, lat, rd, err, n_re, n_we, rdy);
      checks++; if (rd !== v[i].exp) begin errors++; $display("FAIL ld_sub_data[%0d]: got %h expected %h", i, rd, v[i].exp); end
      checks++; if (lat !== RL) begin errors++; $display("FAIL ld_sub_latency[%0d]: got %0d expected %0d", i, lat, RL); end
    end
  endtask

  task automatic test_store_sub();
    int lat, n_re, n_we; logic [31:0] rd; logic err, rdy;
    preload(32'h10, 32'h11223344);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000AB, lat, rd, err, n_re, n_we, rdy);
    checks++; if (lat !== RL + 1) begin errors++; $display("FAIL sb_latency: got %0d expected %0d", lat, RL + 1); end
    checks++; if (n_re !== RL) begin errors++; $display("FAIL sb_re_cycles: got %0d expected %0d", n_re, RL); end
    checks++; if (n_we !== 1) begin errors++; $display("FAIL sb_we_cycles: got %0d expected 1", n_we); end
    checks++; if (last_we_addr !== 32'h10) begin errors++; $display("FAIL sb_we_addr: got %h expected 00000010", last_we_addr); end
    checks++; if (last_we_data !== 32'h11AB3344) begin errors++; $display("FAIL sb_we_data: got %h expected 11ab3344", last_we_data); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL sb_resp: got rdata=%h err=%b expected 00000000/0", rd, err); end
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, lat, rd, err, n_re, n_we, rdy);
    checks++; if (lat !== RL + 1) begin errors++; $display("FAIL sh_latency: got %0d expected %0d", lat, RL + 1); end
    checks++; if (mem_words[4] !== 32'h11ABBEEF) begin errors++; $display("FAIL sh_mem: got %h expected 11abbeef", mem_words[4]); end
  endtask

  task automatic test_back_to_back();
    int lat, n_re, n_we; logic [31:0] rd; logic err, rdy;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hDEADBEEF, lat, rd, err, n_re, n_we, rdy);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d expected 1", lat); end
    checks++; if (n_re !== 0 || n_we !== 1) begin errors++; $display("FAIL sw_strobes: got re=%0d we=%0d expected re=0 we=1", n_re, n_we); end
    checks++; if (last_we_addr !== 32'h20 || last_we_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write: got %h@%h expected deadbeef@00000020", last_we_data, last_we_addr); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sw_ready_in_resp: got %b expected 1", rdy); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_lw_data: got %h expected deadbeef", rd); end
    checks++; if (lat !== RL) begin errors++; $display("FAIL b2b_lw_latency: got %0d expected %0d", lat, RL); end
  endtask

  task automatic test_errors();
    int lat, n_re, n_we; logic [31:0] rd; logic err, rdy;
    preload(32'h10, 32'h8899AABB);
    preload(32'h3FC, 32'hCAFEF00D);
    do_req(1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL size11: got err=%b lat=%0d expected err=1 lat=1", err, lat); end
    checks++; if (n_re !== 0 || n_we !== 0 || rd !== 32'h0) begin errors++; $display("FAIL size11_quiet: got re=%0d we=%0d rdata=%h expected 0/0/0", n_re, n_we, rd); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b1 || lat !== 1 || n_re !== 0) begin errors++; $display("FAIL range_lw: got err=%b lat=%0d re=%0d expected 1/1/0", err, lat, n_re); end
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h401, 32'h55, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b1 || n_we !== 0 || n_re !== 0) begin errors++; $display("FAIL range_sb: got err=%b re=%0d we=%0d expected 1/0/0", err, n_re, n_we); end
`ifdef LSU_MISALIGN_ERR_EN
    do_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b1 || lat !== 1 || n_re !== 0) begin errors++; $display("FAIL mis_lh: got err=%b lat=%0d re=%0d expected 1/1/0", err, lat, n_re); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h3FE, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL mis_lw: got err=%b lat=%0d expected 1/1", err, lat); end
`else
    do_req(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b0 || rd !== 32'hFFFF8899) begin errors++; $display("FAIL mis_lh: got err=%b rdata=%h expected 0/ffff8899", err, rd); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h3FE, 32'h0, lat, rd, err, n_re, n_we, rdy);
    checks++; if (err !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_lw: got err=%b rdata=%h expected 0/cafef00d", err, rd); end
`endif
  endtask

  task automatic test_reset_mid();
    int we0; int resp_seen;
    preload(32'h10, 32'h11223344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_HALF;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h12; bus.req_wdata = 32'h00005566;
    we0 = we_total;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.mem_re !== 1'b1 || bus.req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy: got re=%b ready=%b expected 1/0", bus.mem_re, bus.req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.mem_re, bus.mem_we, bus.resp_valid, bus.req_ready} !== 4'b0000) begin errors++; $display("FAIL mid_outputs: got %b expected 0000", {bus.mem_re, bus.mem_we, bus.resp_valid, bus.req_ready}); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL mid_bus_zero: got addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) resp_seen++;
    end
    checks++; if (resp_seen !== 0) begin errors++; $display("FAIL mid_no_resp: got %0d expected 0", resp_seen); end
    checks++; if (we_total !== we0) begin errors++; $display("FAIL mid_no_write: got %0d expected %0d", we_total, we0); end
    checks++; if (mem_words[4] !== 32'h11223344) begin errors++; $display("FAIL mid_mem: got %h expected 11223344", mem_words[4]); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL re_we_exclusive: got %b expected 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_sub();
    test_store_sub();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
